channel_buffer_reader: RTL and testbench

//  Read-side companion to the per-channel sample buffers (14 ch x 10 samples x 8 bit).
//  On request, walks the buffer read port and streams one framed byte sequence per channel.
//  - Frame: header byte, then samples oldest-first, then optional checksum.
//  - Output uses a valid/ready handshake, suitable for driving uo_out or a UART TX.

---
 rtl/sample_buffer_pkg.sv | 29 ++
 rtl/channel_buffer_reader_stream_out_reg.sv | 35 +++
 rtl/channel_buffer_reader.sv | 177 +++++++++++++++++
 tb/tb_channel_buffer_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_buffer_pkg.sv
// sample_buffer_pkg: shared sizing, header tag and reader FSM states for the sample buffers
// Contents:
//   NUMBER_OF_CHANNELS, NUMBER_OF_BITS, SAMPLES_BUFFER_SIZE  buffer geometry
//   CH_W, IDX_W                                              channel / sample index widths
//   HDR_TAG                                                  frame header marker bit
//   rdr_state_t                                              channel_buffer_reader FSM states
//   hdr_byte()                                               header byte for a channel id
package sample_buffer_pkg;
    localparam int NUMBER_OF_CHANNELS  = 14;
    localparam int NUMBER_OF_BITS      = 8;
    localparam int SAMPLES_BUFFER_SIZE = 10;
    localparam int CH_W                = 4;
    localparam int IDX_W               = 4;
    localparam logic [NUMBER_OF_BITS-1:0] HDR_TAG = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_CAP,
        S_DATA,
        S_CSUM,
        S_NEXT
    } rdr_state_t;

    function automatic logic [NUMBER_OF_BITS-1:0] hdr_byte(input logic [CH_W-1:0] c);
        return HDR_TAG | NUMBER_OF_BITS'(c);
    endfunction
endpackage

// File: rtl/channel_buffer_reader_stream_out_reg.sv
// stream_out_reg: registered valid/ready output stage (hold register + valid flag)
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load                  capture load_data/load_last and raise valid (wins over a same-cycle handshake)
//   load_data, load_last  byte and end-of-request marker to present
//   ready                 sink ready
//   valid, data, last     registered outputs, stable until valid && ready
module stream_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end
endmodule

// File: rtl/channel_buffer_reader.sv
// channel_buffer_reader: streams framed per-channel dumps (header, samples oldest-first, optional checksum)
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   req_valid/req_ready                dump request handshake (ready only in IDLE)
//   req_all, req_channel               sweep all channels, or dump one channel
//   rd_en, rd_channel, rd_index        buffer read port strobe/address
//   rd_data                            buffer read data, valid one cycle after rd_en
//   out_valid/out_ready, out_data      output byte handshake
//   out_last                           final byte of the whole request
//   busy                               FSM not in IDLE
//   err                                one-cycle pulse on a rejected channel id
// Build option: define CHANNEL_BUFFER_CHECKSUM_EN to append a zero-sum checksum byte per frame.
module channel_buffer_reader
    import sample_buffer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_all,
    input  logic [CH_W-1:0]           req_channel,
    output logic                      rd_en,
    output logic [CH_W-1:0]           rd_channel,
    output logic [IDX_W-1:0]          rd_index,
    input  logic [NUMBER_OF_BITS-1:0] rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUMBER_OF_BITS-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err
);
    rdr_state_t                state;
    logic                      all_q;
    logic [CH_W-1:0]           ch;
    logic [IDX_W-1:0]          idx;
    logic [CH_W-1:0]           start_ch;
    logic                      accept;
    logic                      bad_ch;
    logic                      hs;
    logic                      more_ch;
    logic                      last_idx;
    logic                      load;
    logic                      load_last;
    logic [NUMBER_OF_BITS-1:0] load_data;
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
    logic [NUMBER_OF_BITS-1:0] csum;
`endif

    assign req_ready = state == S_IDLE;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign bad_ch    = !req_all && req_channel >= CH_W'(NUMBER_OF_CHANNELS);
    assign start_ch  = req_all ? '0 : req_channel;
    assign hs        = out_valid && out_ready;
    assign more_ch   = all_q && ch < CH_W'(NUMBER_OF_CHANNELS - 1);
    assign last_idx  = idx == IDX_W'(SAMPLES_BUFFER_SIZE - 1);

    // Bytes are loaded into the output stage on the edge that enters the
    // presenting state, so out_valid rises exactly one cycle after the event.
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        if (state == S_IDLE && accept && !bad_ch) begin
            load      = 1'b1;
            load_data = hdr_byte(start_ch);
        end else if (state == S_CAP) begin
            load      = 1'b1;
            load_data = rd_data;
`ifndef CHANNEL_BUFFER_CHECKSUM_EN
            load_last = last_idx && !more_ch;
`endif
        end else if (state == S_NEXT && more_ch) begin
            load      = 1'b1;
            load_data = hdr_byte(ch + 1'b1);
        end
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
        else if (state == S_DATA && hs && last_idx) begin
            // csum already holds header + every sample; its negation zeroes the frame sum
            load      = 1'b1;
            load_data = -csum;
            load_last = !more_ch;
        end
`endif
    end

    stream_out_reg #(.W(NUMBER_OF_BITS)) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .last      (out_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            all_q      <= 1'b0;
            ch         <= '0;
            idx        <= '0;
            rd_en      <= 1'b0;
            rd_channel <= '0;
            rd_index   <= '0;
            err        <= 1'b0;
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            rd_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (bad_ch) begin
                        err <= 1'b1;
                    end else begin
                        all_q <= req_all;
                        ch    <= start_ch;
                        idx   <= '0;
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
                        csum  <= hdr_byte(start_ch);
`endif
                        state <= S_HDR;
                    end
                end
                S_HDR: if (hs) begin
                    rd_en      <= 1'b1;
                    rd_channel <= ch;
                    rd_index   <= idx;
                    state      <= S_RD;
                end
                S_RD: state <= S_CAP;
                S_CAP: begin
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
                    csum  <= csum + rd_data;
`endif
                    state <= S_DATA;
                end
                S_DATA: if (hs) begin
                    if (!last_idx) begin
                        idx        <= idx + 1'b1;
                        rd_en      <= 1'b1;
                        rd_channel <= ch;
                        rd_index   <= idx + 1'b1;
                        state      <= S_RD;
                    end else begin
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= S_NEXT;
`endif
                    end
                end
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
                S_CSUM: if (hs) state <= S_NEXT;
`endif
                S_NEXT: begin
                    if (more_ch) begin
                        ch    <= ch + 1'b1;
                        idx   <= '0;
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
                        csum  <= hdr_byte(ch + 1'b1);
`endif
                        state <= S_HDR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_channel_buffer_reader.sv
// tb_channel_buffer_reader: scoreboard bench for channel_buffer_reader
module tb_channel_buffer_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_all = 1'b0;
    logic [3:0] req_channel = 4'd0;
    logic       rd_en;
    logic [3:0] rd_channel;
    logic [3:0] rd_index;
    logic [7:0] rd_data = 8'hEE;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       err;

    int pass = 0;
    int fails = 0;
    int total = 0;
    int cnt_rd = 0;
    int cnt_ov = 0;
    logic [8:0] q[$];
    logic       hold_v = 1'b0;
    logic [8:0] hold_d = '0;

    channel_buffer_reader dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_all     (req_all),
        .req_channel (req_channel),
        .rd_en       (rd_en),
        .rd_channel  (rd_channel),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sample(input int c, input int i);
        return c == 3 ? 8'(16 + i) : 8'(c * 16 + i) ^ 8'h5A;
    endfunction

    // buffer model: data appears exactly one cycle after rd_en, garbage otherwise
    always @(posedge clk) rd_data <= rd_en ? sample(int'(rd_channel), int'(rd_index)) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int c, input bit fin);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h80 | 8'(c);
        q.push_back({1'b0, s});
        for (int i = 0; i < 10; i++) begin
            b = sample(c, i);
            s = s + b;
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
            q.push_back({1'b0, b});
`else
            q.push_back({fin && i == 9, b});
`endif
        end
`ifdef CHANNEL_BUFFER_CHECKSUM_EN
        q.push_back({fin, -s});
`endif
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {23'd0, out_last, out_data}, {23'd0, hold_d});
            end
            hold_v = out_valid && !out_ready;
            hold_d = {out_last, out_data};
            if (out_valid) cnt_ov++;
            if (rd_en) cnt_rd++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_byte", {23'd0, out_last, out_data}, 32'h1FF);
                else chk("byte", {23'd0, out_last, out_data}, {23'd0, q.pop_front()});
            end
        end
    end

    // issue one request at posedge+1; returns at the accept edge + 1
    task automatic do_req(input bit all, input logic [3:0] c);
        req_valid   = 1'b1;
        req_all     = all;
        req_channel = c;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run(input bit stall, input int budget);
        int n = 0;
        int early = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!busy) early++;
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        chk("done_in_budget", {31'd0, n < budget}, 32'd1);
        chk("busy_held", early, 0);
    endtask

    initial begin
        int rd0;
        int ov0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: single dump of channel 3
        push_frame(3, 1'b1);
        do_req(1'b0, 4'd3);
        chk("hdr_latency", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h83});
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        run(1'b0, 200);

        // 2: sweep every channel
        for (int c = 0; c < 14; c++) push_frame(c, c == 13);
        do_req(1'b1, 4'd9);
        chk("sweep_hdr0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h80});
        run(1'b0, 3000);

        // 3: same dump as test 1 under random sink stalls
        push_frame(3, 1'b1);
        do_req(1'b0, 4'd3);
        run(1'b1, 1000);

        // 4: rejected channel id
        rd0 = cnt_rd;
        ov0 = cnt_ov;
        do_req(1'b0, 4'd14);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("err_req_ready_held", {31'd0, req_ready}, 32'd1);
        chk("err_no_rd", cnt_rd, rd0);
        chk("err_no_out", cnt_ov, ov0);

        // 5: reset during the 5th sample read of channel 2
        push_frame(2, 1'b1);
        do_req(1'b0, 4'd2);
        for (int n = 0; n < 200 && !(rd_en && rd_index == 4'd4); n++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_5th_sample", {28'd0, rd_index}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_last", {31'd0, out_last}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_frame(5, 1'b1);
        do_req(1'b0, 4'd5);
        chk("post_rst_hdr", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h85});
        run(1'b0, 200);

        // 6: request while busy is ignored
        push_frame(7, 1'b1);
        do_req(1'b0, 4'd7);
        repeat (6) @(posedge clk);
        #1;
        req_valid   = 1'b1;
        req_all     = 1'b1;
        req_channel = 4'd1;
        chk("busy_during_req", {31'd0, busy}, 32'd1);
        chk("not_ready_busy", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        run(1'b0, 200);
        ov0 = cnt_ov;
        repeat (5) @(posedge clk);
        #1;
        chk("no_queued_req", cnt_ov, ov0);
        chk("idle_after", {31'd0, busy}, 32'd0);
        chk("sb_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
